// File: rtl/dm_cache_ctrl_pkg.sv
// Shared constants, FSM state type and address-field helpers for the direct-mapped
// cache controller.
package cache_pkg;

  localparam int unsigned TAG_W  = 20;
  localparam int unsigned IDX_W  = 7;
  localparam int unsigned WRD_W  = 3;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [2:0] {
    StIdle,
    StCompare,
    StWriteback,
    StAllocate,
    StFill
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
    return addr[IDX_W+WRD_W+2 +: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
    return addr[WRD_W+2 +: IDX_W];
  endfunction

  function automatic logic [WRD_W-1:0] addr_word(input logic [31:0] addr);
    return addr[2 +: WRD_W];
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU, cache-array and main-memory signal bundle around the cache controller.
// master = controller side, slave = CPU/array/memory side.
interface dm_cache_ctrl_if;
  import cache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_byte_en;
  logic              cpu_ready;
  logic [31:0]       cpu_rdata;

  logic              c_enable;
  logic              c_write;
  logic              c_compare;
  logic [TAG_W-1:0]  c_tag;
  logic [IDX_W-1:0]  c_index;
  logic [WRD_W-1:0]  c_word;
  logic [31:0]       c_data_in;
  logic [LINE_W-1:0] c_line_in;
  logic [3:0]        c_byte_w_en;
  logic              c_hit;
  logic              c_dirty;
  logic              c_valid;
  logic [TAG_W-1:0]  c_tag_out;
  logic [31:0]       c_data_out;
  logic [LINE_W-1:0] c_line_out;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wline;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rline;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
    output cpu_ready, cpu_rdata,
    output c_enable, c_write, c_compare, c_tag, c_index, c_word, c_data_in, c_line_in,
    output c_byte_w_en,
    input  c_hit, c_dirty, c_valid, c_tag_out, c_data_out, c_line_out,
    output mem_req, mem_we, mem_addr, mem_wline,
    input  mem_ack, mem_rline
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
    input  cpu_ready, cpu_rdata,
    input  c_enable, c_write, c_compare, c_tag, c_index, c_word, c_data_in, c_line_in,
    input  c_byte_w_en,
    output c_hit, c_dirty, c_valid, c_tag_out, c_data_out, c_line_out,
    input  mem_req, mem_we, mem_addr, mem_wline,
    output mem_ack, mem_rline
  );

endinterface

// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate controller for a direct-mapped cache array: one CPU access
// at a time, dirty-victim write-back, line fill, then a guaranteed-hit retry.
module dm_cache_ctrl #(
  parameter int unsigned TAG_W  = cache_pkg::TAG_W,
  parameter int unsigned IDX_W  = cache_pkg::IDX_W,
  parameter int unsigned WRD_W  = cache_pkg::WRD_W,
  parameter int unsigned LINE_W = cache_pkg::LINE_W
) (
  input  logic            clk,
  input  logic            rst,
  dm_cache_ctrl_if.master bus,
  output logic [31:0]     hit_cnt,
  output logic [31:0]     miss_cnt
);
  import cache_pkg::*;

  localparam int unsigned OffW = 32 - TAG_W - IDX_W;

  state_e state_q, state_d;

  logic [31:0]       req_addr_q;
  logic              req_we_q;
  logic [31:0]       req_wdata_q;
  logic [3:0]        req_be_q;
  logic [TAG_W-1:0]  victim_tag_q;
  logic [LINE_W-1:0] victim_line_q;
  logic [LINE_W-1:0] fill_line_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;
  // Set while the post-fill retry is in flight so it is not counted again.
  logic              retry_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_index;
  logic [WRD_W-1:0] req_word;
  logic             accept;
  logic             cmp_hit;
  logic             cmp_miss;

  assign req_tag   = addr_tag(req_addr_q);
  assign req_index = addr_index(req_addr_q);
  assign req_word  = addr_word(req_addr_q);

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    cmp_hit         = 1'b0;
    cmp_miss        = 1'b0;
    bus.cpu_ready   = 1'b0;
    bus.cpu_rdata   = '0;
    bus.c_enable    = 1'b0;
    bus.c_write     = 1'b0;
    bus.c_compare   = 1'b0;
    bus.c_tag       = '0;
    bus.c_index     = '0;
    bus.c_word      = '0;
    bus.c_data_in   = '0;
    bus.c_line_in   = '0;
    bus.c_byte_w_en = '0;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wline   = '0;

    case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          accept  = 1'b1;
          state_d = StCompare;
        end
      end
      StCompare: begin
        bus.c_enable    = 1'b1;
        bus.c_compare   = 1'b1;
        bus.c_write     = req_we_q;
        bus.c_tag       = req_tag;
        bus.c_index     = req_index;
        bus.c_word      = req_word;
        bus.c_data_in   = req_wdata_q;
        bus.c_byte_w_en = req_we_q ? req_be_q : 4'b0000;
        if (bus.c_hit) begin
          cmp_hit       = 1'b1;
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = req_we_q ? 32'h0 : bus.c_data_out;
          state_d       = StIdle;
        end else begin
          cmp_miss = 1'b1;
          state_d  = (bus.c_valid && bus.c_dirty) ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {victim_tag_q, req_index, {OffW{1'b0}}};
        bus.mem_wline = victim_line_q;
        if (bus.mem_ack) state_d = StAllocate;
      end
      StAllocate: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, req_index, {OffW{1'b0}}};
        if (bus.mem_ack) state_d = StFill;
      end
      StFill: begin
        bus.c_enable  = 1'b1;
        bus.c_write   = 1'b1;
        bus.c_tag     = req_tag;
        bus.c_index   = req_index;
        bus.c_word    = req_word;
        bus.c_line_in = fill_line_q;
        state_d       = StCompare;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      req_addr_q    <= '0;
      req_we_q      <= 1'b0;
      req_wdata_q   <= '0;
      req_be_q      <= '0;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      fill_line_q   <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      retry_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q  <= bus.cpu_addr;
        req_we_q    <= bus.cpu_we;
        req_wdata_q <= bus.cpu_wdata;
        req_be_q    <= bus.cpu_byte_en;
        retry_q     <= 1'b0;
      end
      // Only the first attempt of an access counts toward hit/miss statistics.
      if (cmp_hit) begin
        if (!retry_q) hit_cnt_q <= hit_cnt_q + 32'd1;
        retry_q <= 1'b0;
      end
      if (cmp_miss) begin
        if (!retry_q) miss_cnt_q <= miss_cnt_q + 32'd1;
        victim_tag_q  <= bus.c_tag_out;
        victim_line_q <= bus.c_line_out;
      end
      if (state_q == StAllocate && bus.mem_ack) fill_line_q <= bus.mem_rline;
      if (state_q == StFill) retry_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl with a behavioural cache array and a
// latency-programmable main memory.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  dm_cache_ctrl_if bus ();

  dm_cache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int mem_lat = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic        chk_w2;
    logic [31:0] w2;
  } mem_exp_t;

  logic [31:0] exp_cpu[$];
  mem_exp_t    exp_mem[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s: got 0x%08h, want none", name, act);
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + 32'(i);
    return l;
  endfunction

  // Behavioural direct-mapped array: combinational read, posedge write.
  logic [19:0]  a_tag   [128];
  logic         a_val   [128];
  logic         a_dirty [128];
  logic [255:0] a_line  [128];
  logic         arr_clear;
  logic [31:0]  merged;

  always_comb begin
    bus.c_tag_out  = a_tag[bus.c_index];
    bus.c_valid    = a_val[bus.c_index];
    bus.c_dirty    = a_dirty[bus.c_index];
    bus.c_line_out = a_line[bus.c_index];
    bus.c_data_out = a_line[bus.c_index][{bus.c_word, 5'b0} +: 32];
    bus.c_hit      = bus.c_enable && bus.c_compare && a_val[bus.c_index]
                     && (a_tag[bus.c_index] == bus.c_tag);
    merged = bus.c_data_out;
    for (int b = 0; b < 4; b++)
      if (bus.c_byte_w_en[b]) merged[b*8 +: 8] = bus.c_data_in[b*8 +: 8];
  end

  always @(posedge clk) begin
    if (arr_clear) begin
      for (int i = 0; i < 128; i++) begin
        a_val[i]   <= 1'b0;
        a_dirty[i] <= 1'b0;
        a_tag[i]   <= '0;
        a_line[i]  <= '0;
      end
    end else if (bus.c_enable && bus.c_write) begin
      if (bus.c_compare) begin
        if (a_tag[bus.c_index] == bus.c_tag) begin
          a_line[bus.c_index][{bus.c_word, 5'b0} +: 32] <= merged;
          a_dirty[bus.c_index] <= 1'b1;
        end
      end else begin
        a_line[bus.c_index]  <= bus.c_line_in;
        a_tag[bus.c_index]   <= bus.c_tag;
        a_val[bus.c_index]   <= 1'b1;
        a_dirty[bus.c_index] <= 1'b0;
      end
    end
  end

  // Main memory responder: checks each transaction against exp_mem and its stability.
  logic [255:0] mem_q [logic [31:0]];

  initial begin
    logic         t_we;
    logic [31:0]  t_addr;
    logic [255:0] t_wline;
    logic         stable;
    logic         aborted;
    mem_exp_t     e;
    mem_q[32'h0000_1040] = mk_line(32'h10);
    mem_q[32'h0000_2040] = mk_line(32'h20);
    mem_q[32'h0000_3040] = mk_line(32'h30);
    bus.mem_ack   = 1'b0;
    bus.mem_rline = '0;
    @(posedge clk); #1;
    forever begin
      if (bus.mem_req === 1'b1) begin
        t_we    = bus.mem_we;
        t_addr  = bus.mem_addr;
        t_wline = bus.mem_wline;
        stable  = 1'b1;
        aborted = 1'b0;
        if (exp_mem.size() == 0) begin
          fail_now("mem_unexpected_txn", t_addr);
        end else begin
          e = exp_mem.pop_front();
          check("mem_we", 32'(t_we), 32'(e.we));
          check("mem_addr", t_addr, e.addr);
          if (e.chk_w2) check("mem_wline_w2", t_wline[95:64], e.w2);
        end
        for (int k = 0; k < mem_lat; k++) begin
          @(posedge clk); #1;
          if (bus.mem_req !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (bus.mem_we !== t_we || bus.mem_addr !== t_addr || bus.mem_wline !== t_wline)
            stable = 1'b0;
        end
        check("mem_stable", 32'(stable), 32'd1);
        if (!aborted) begin
          bus.mem_rline = t_we ? '0 : (mem_q.exists(t_addr) ? mem_q[t_addr] : '0);
          bus.mem_ack   = 1'b1;
          @(posedge clk); #1;
          bus.mem_ack   = 1'b0;
          bus.mem_rline = '0;
          if (t_we) mem_q[t_addr] = t_wline;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  end

  // CPU response monitor.
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (bus.cpu_ready === 1'b1) begin
      if (exp_cpu.size() == 0) begin
        fail_now("cpu_unexpected_ready", bus.cpu_rdata);
      end else begin
        exp_rd = exp_cpu.pop_front();
        check("cpu_rdata", bus.cpu_rdata, exp_rd);
      end
    end
  end

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic chk,
                          input logic [31:0] w2);
    mem_exp_t e;
    e.we = we; e.addr = addr; e.chk_w2 = chk; e.w2 = w2;
    exp_mem.push_back(e);
  endtask

  // Starts in an IDLE cycle just after a posedge; returns in the next IDLE cycle.
  task automatic cpu_access(input string name, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] exp_rd, input int exp_lat);
    int lat;
    exp_cpu.push_back(exp_rd);
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = we;
    bus.cpu_addr    = addr;
    bus.cpu_wdata   = wd;
    bus.cpu_byte_en = be;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (bus.cpu_ready !== 1'b1 && lat < 200);
    bus.cpu_req = 1'b0;
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int guard;
    rst             = 1'b0;
    arr_clear       = 1'b1;
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_addr    = '0;
    bus.cpu_wdata   = '0;
    bus.cpu_byte_en = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_c_enable", 32'(bus.c_enable), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_hit_cnt", hit_cnt, 32'h0);
    check("rst_miss_cnt", miss_cnt, 32'h0);
    rst       = 1'b1;
    arr_clear = 1'b0;
    @(posedge clk); #1;

    // Cold load miss, clean allocate.
    push_mem(1'b0, 32'h0000_1040, 1'b0, 32'h0);
    cpu_access("cold_load", 1'b0, 32'h0000_1040, 32'h0, 4'h0, 32'h10, 6);
    check("cold_miss_cnt", miss_cnt, 32'd1);
    check("cold_hit_cnt", hit_cnt, 32'd0);

    cpu_access("hit_load", 1'b0, 32'h0000_1044, 32'h0, 4'h0, 32'h11, 1);
    check("hit_hit_cnt", hit_cnt, 32'd1);
    check("hit_no_mem", 32'(exp_mem.size()), 32'd0);

    // Partial store then read-back.
    cpu_access("store_lo", 1'b1, 32'h0000_1048, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1);
    cpu_access("load_back", 1'b0, 32'h0000_1048, 32'h0, 4'h0, 32'h0000_BEEF, 1);
    check("store_hit_cnt", hit_cnt, 32'd3);

    // Conflict miss with dirty victim.
    push_mem(1'b1, 32'h0000_1040, 1'b1, 32'h0000_BEEF);
    push_mem(1'b0, 32'h0000_2040, 1'b0, 32'h0);
    cpu_access("dirty_miss", 1'b0, 32'h0000_2040, 32'h0, 4'h0, 32'h20, 9);
    check("dirty_miss_cnt", miss_cnt, 32'd2);

    // Victim was clean; the written-back word must come back from memory.
    push_mem(1'b0, 32'h0000_1040, 1'b0, 32'h0);
    cpu_access("wb_reload", 1'b0, 32'h0000_1048, 32'h0, 4'h0, 32'h0000_BEEF, 6);
    check("wb_reload_miss_cnt", miss_cnt, 32'd3);

    // Dirty miss under a 20-cycle memory stall.
    cpu_access("store_hi", 1'b1, 32'h0000_1048, 32'h1234_5678, 4'b1100, 32'h0, 1);
    mem_lat = 20;
    push_mem(1'b1, 32'h0000_1040, 1'b1, 32'h1234_BEEF);
    push_mem(1'b0, 32'h0000_2040, 1'b0, 32'h0);
    cpu_access("stall_miss", 1'b0, 32'h0000_2040, 32'h0, 4'h0, 32'h20, 45);
    check("stall_miss_cnt", miss_cnt, 32'd4);
    check("stall_hit_cnt", hit_cnt, 32'd4);

    // Reset in the middle of an allocate that never gets acked.
    mem_lat = 1000;
    push_mem(1'b0, 32'h0000_3040, 1'b0, 32'h0);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_3040;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (bus.mem_req !== 1'b1 && guard < 20);
    bus.cpu_req = 1'b0;
    check("abort_reached_alloc", 32'(bus.mem_req), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_req", 32'(bus.mem_req), 32'd0);
    check("abort_c_enable", 32'(bus.c_enable), 32'd0);
    check("abort_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("abort_hit_cnt", hit_cnt, 32'd0);
    check("abort_miss_cnt", miss_cnt, 32'd0);
    rst     = 1'b1;
    mem_lat = 2;
    repeat (2) @(posedge clk);
    #1;

    push_mem(1'b0, 32'h0000_3040, 1'b0, 32'h0);
    cpu_access("post_abort", 1'b0, 32'h0000_3040, 32'h0, 4'h0, 32'h30, 6);
    check("post_abort_miss_cnt", miss_cnt, 32'd1);
    check("post_abort_hit_cnt", hit_cnt, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    check("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    check("mem_queue_drained", 32'(exp_mem.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
